// File: rtl/frac_clock_divider_if.sv
// frac_clock_divider_if: run enable, configuration handshake and divided-clock outputs
//   en, cfg_valid, cfg_mode, cfg_value : master -> divider
//   cfg_ready, clk_div, tick           : divider -> master
interface frac_clock_divider_if #(
    parameter int VAL_WIDTH = 32
);
    logic                 en;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic                 cfg_mode;
    logic [VAL_WIDTH-1:0] cfg_value;
    logic                 clk_div;
    logic                 tick;
    modport master (output en, cfg_valid, cfg_mode, cfg_value, input cfg_ready, clk_div, tick);
    modport slave (input en, cfg_valid, cfg_mode, cfg_value, output cfg_ready, clk_div, tick);
endinterface

// File: rtl/frac_clock_divider.sv
// frac_clock_divider: integer/fractional clock divider with handshake-driven reconfiguration
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of frac_clock_divider_if (en, cfg_*, clk_div, tick)
module frac_clock_divider #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEFAULT_FREQ = 1_000,
    parameter int DIV_WIDTH    = 32,
    parameter int ACC_WIDTH    = 32
) (
    input logic                 clk,
    input logic                 rst,
    frac_clock_divider_if.slave bus
);
    localparam int          VW      = DIV_WIDTH > ACC_WIDTH ? DIV_WIDTH : ACC_WIDTH;
    localparam logic [63:0] H_RST   = 64'(CLK_FREQ / (2 * DEFAULT_FREQ));
    localparam logic [63:0] INC_RST = (64'(DEFAULT_FREQ) << ACC_WIDTH) / 64'(CLK_FREQ);

    logic                 mode_q, mode_d, pend_q, pend_d, pmode_q, pmode_d;
    logic                 clk_div_q, clk_div_d, tick_q, tick_d;
    logic [DIV_WIDTH-1:0] h_q, h_d, count_q, count_d;
    logic [ACC_WIDTH-1:0] inc_q, inc_d, acc_q, acc_d;
    logic [VW-1:0]        pval_q, pval_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 int_end, bound, apply, xfer;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, inc_q};
        // ">=" rather than "==" makes H = 0 toggle every cycle like H = 1
        int_end = (count_q + DIV_WIDTH'(1)) >= h_q;
        // safe apply point: falling edge of a high phase, or accumulator wrap
        bound   = mode_q ? sum[ACC_WIDTH] : (int_end & clk_div_q);
        xfer    = bus.cfg_valid & ~pend_q;
        // pend_q is only set after the transfer edge, so a same-edge boundary is skipped
        apply   = pend_q & (~bus.en | bound);
        pend_d  = apply ? 1'b0 : (xfer | pend_q);
        pmode_d = xfer ? bus.cfg_mode : pmode_q;
        pval_d  = xfer ? bus.cfg_value : pval_q;
        mode_d  = apply ? pmode_q : mode_q;
        h_d     = apply ? pval_q[DIV_WIDTH-1:0] : h_q;
        inc_d   = apply ? pval_q[ACC_WIDTH-1:0] : inc_q;
        count_d = apply ? '0 : (bus.en & ~mode_q) ? (int_end ? '0 : count_q + DIV_WIDTH'(1)) : count_q;
        acc_d   = apply ? '0 : (bus.en & mode_q) ? sum[ACC_WIDTH-1:0] : acc_q;
        clk_div_d = apply ? 1'b0 : ~bus.en ? clk_div_q : mode_q ? sum[ACC_WIDTH-1] : clk_div_q ^ int_end;
        tick_d  = bus.en & clk_div_d & ~clk_div_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= 1'b0;
            h_q       <= H_RST[DIV_WIDTH-1:0];
            inc_q     <= INC_RST[ACC_WIDTH-1:0];
            count_q   <= '0;
            acc_q     <= '0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
            pend_q    <= 1'b0;
            pmode_q   <= 1'b0;
            pval_q    <= '0;
        end else begin
            mode_q    <= mode_d;
            h_q       <= h_d;
            inc_q     <= inc_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
            pend_q    <= pend_d;
            pmode_q   <= pmode_d;
            pval_q    <= pval_d;
        end
    end

    assign bus.cfg_ready = ~pend_q;
    assign bus.clk_div   = clk_div_q;
    assign bus.tick      = tick_q;
endmodule

// File: tb/tb_frac_clock_divider.sv
// tb_frac_clock_divider: directed checks of reset, integer/fractional modes, gating and reconfiguration
module tb_frac_clock_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors = 0;
    int   n = 0;
    int   t = 0;
    int   ticks = 0;
    logic bad = 1'b0;

    frac_clock_divider_if #(.VAL_WIDTH(32)) bus();

    frac_clock_divider dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic m, input logic [31:0] v);
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = m;
        bus.cfg_value = v;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        bus.en = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_mode = 1'b0;
        bus.cfg_value = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        chk("rst_clk_div", bus.clk_div, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_ready", bus.cfg_ready, 1);
        while (!bus.clk_div && n < 30000) step();
        chk("first_rise_edge", n, 25000);
        chk("first_rise_tick", bus.tick, 1);
        step();
        chk("tick_width", bus.tick, 0);
        repeat (99) step();
        cfg(1'b0, 32'd3);
        chk("h3_ready_low", bus.cfg_ready, 0);
        while (bus.clk_div && n < 60000) step();
        chk("old_high_completes", n, 50000);
        chk("h3_ready_back", bus.cfg_ready, 1);
        t = n;
        while (!bus.clk_div && n < t + 20) step();
        chk("h3_rise", n - t, 3);
        chk("h3_tick", bus.tick, 1);
        while (bus.clk_div && n < t + 20) step();
        chk("h3_fall", n - t, 6);
        while (!bus.clk_div && n < t + 20) step();
        chk("h3_rise2", n - t, 9);
        step();
        bus.en = 1'b0;
        repeat (17) begin
            step();
            bad = bad | (bus.clk_div !== 1'b1) | (bus.tick !== 1'b0);
        end
        chk("freeze_hold", bad, 0);
        bus.en = 1'b1;
        t = n;
        while (bus.clk_div && n < t + 10) step();
        chk("resume_fall", n - t, 2);
        bus.en = 1'b0;
        cfg(1'b1, 32'h8000_0000);
        chk("gated_ready_low", bus.cfg_ready, 0);
        step();
        chk("gated_apply_ready", bus.cfg_ready, 1);
        chk("gated_apply_clk_div", bus.clk_div, 0);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("inc_half_alt", bus.clk_div, (i % 2 == 0) ? 1 : 0);
        end
        cfg(1'b1, 32'h6666_6666);
        t = n;
        while (!bus.cfg_ready && n < t + 10) step();
        chk("frac_apply", bus.cfg_ready, 1);
        repeat (1000) begin
            step();
            ticks += bus.tick;
        end
        chk("frac_20mhz_ticks", ticks, 400);
        cfg(1'b1, 32'h0);
        t = n;
        while (!bus.cfg_ready && n < t + 10) step();
        chk("inc0_apply", bus.cfg_ready, 1);
        bad = 1'b0;
        repeat (20) begin
            step();
            bad = bad | bus.clk_div | bus.tick;
        end
        chk("inc0_quiet", bad, 0);
        bus.en = 1'b0;
        cfg(1'b0, 32'h0);
        step();
        chk("h0_apply", bus.cfg_ready, 1);
        bus.en = 1'b1;
        step();
        chk("h0_rise", bus.clk_div, 1);
        chk("h0_tick", bus.tick, 1);
        step();
        chk("h0_fall", bus.clk_div, 0);
        chk("h0_tick_low", bus.tick, 0);
        step();
        chk("h0_rise2", bus.clk_div, 1);
        cfg(1'b0, 32'd1000);
        t = n;
        while (!bus.cfg_ready && n < t + 10) step();
        chk("h1000_apply", bus.cfg_ready, 1);
        t = n;
        cfg(1'b0, 32'd7);
        chk("h7_pending", bus.cfg_ready, 0);
        while (!bus.clk_div && n < t + 1100) step();
        chk("h1000_rise", n - t, 1000);
        repeat (10) step();
        #2 rst = 1'b1;
        #1;
        chk("async_clk_div", bus.clk_div, 0);
        chk("async_tick", bus.tick, 0);
        chk("async_ready", bus.cfg_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (!bus.clk_div && n < 30000) step();
        chk("default_restored_rise", n, 25000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/frac_clock_divider.md
# frac_clock_divider

Runtime-programmable clock divider. It produces a divided clock level and a one-cycle tick from the 50 MHz system clock, in either of two modes. Integer mode is an exact counter. Fractional mode is a phase accumulator that can reach frequencies that are not integer divisors, for example 20 MHz. It sits next to the system clock input and feeds clock enables to peripherals (UART, PWM, display scan). Configuration is changed through a valid/ready handshake and is applied only on a clean falling boundary of the output.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz, used only for reset defaults.
- DEFAULT_FREQ, 1_000: output frequency in Hz after reset.
- DIV_WIDTH, 32: width of the half-period count in integer mode.
- ACC_WIDTH, 32: phase accumulator width in fractional mode.

Ports, clock and reset first:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; 0 freezes the divider.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block can accept a configuration.
- cfg_mode  in  1  0 = integer, 1 = fractional.
- cfg_value  in  max(DIV_WIDTH,ACC_WIDTH)  half-period H in integer mode (low DIV_WIDTH bits); phase increment INC in fractional mode (low ACC_WIDTH bits).
- clk_div  out  1  registered divided clock level.
- tick  out  1  one-cycle pulse in the first clk cycle of each clk_div high phase.

## Operation
Reset state (asynchronous):
- mode = 0, H = CLK_FREQ/(2*DEFAULT_FREQ); with the defaults, H = 25000.
- INC = (DEFAULT_FREQ << ACC_WIDTH) / CLK_FREQ, computed in 64 bits.
- count = 0, acc = 0, clk_div = 0, tick = 0.
- cfg_ready = 1, no update pending.

Integer mode:
- If count == H-1: count <= 0, clk_div <= ~clk_div.
- Otherwise: count <= count+1.
- H = 0 behaves as H = 1.
- Output period is 2H clk cycles with exactly 50% duty.

Fractional mode:
- acc <= acc+INC, modulo 2^ACC_WIDTH.
- clk_div <= MSB of the new acc.
- Average output frequency is INC*CLK_FREQ/2^ACC_WIDTH.
- Period jitter is at most one clk cycle.
- INC = 0 holds the output constant.

Tick:
- tick <= 1 exactly when clk_div goes 0→1; otherwise 0.

Configuration handshake:
- Transfer occurs when cfg_valid && cfg_ready. cfg_mode and cfg_value are captured into a pending register, and cfg_ready drops on the next cycle.
- cfg_ready stays low until the pending update is applied, then returns high on the cycle after the apply.
- No further transfer is possible while an update is pending.

Apply boundary:
- Integer mode: the cycle in which clk_div goes 1→0.
- Fractional mode: the cycle in which acc carries out (wraps).
- If en = 0: the next clk edge.
- On apply: mode, H and INC are loaded; count <= 0, acc <= 0, clk_div <= 0, tick <= 0.

Enable:
- en = 0 holds count, acc and clk_div, and forces tick to 0.
- Re-enabling resumes from the held state with no phase loss.

## Timing
- Edges are counted as posedges after rst deasserts.
- Integer mode: clk_div is 1 after edge H, 0 after edge 2H, and repeats with period 2H. tick is high during the cycle after edge H, 3H, …
- Fractional mode: clk_div reflects acc with one register stage. tick aligns with clk_div's rising cycle.
- Update latency: for a transfer at edge t with en = 1, the new setting takes effect at the first apply boundary after t. The first new-rate rising edge follows one new half-period later.
- Transfer and boundary on the same edge: the value is latched only. It is applied at the next boundary, not the current one.
- rst asserted mid-period or with an update pending: immediate return to reset state, and the pending update is discarded.
- clk_div and tick are glitch-free registered outputs.
- No high phase is ever truncated by a reconfiguration.

## Test plan
- Reset with DEFAULT_FREQ = 1000 → clk_div period 50000 cycles, first rise after edge 25000, tick width 1 cycle, cfg_ready = 1.
- Integer reconfig: H = 3 written mid-high-phase → old high phase completes; output then toggles every 3 cycles (period 6); cfg_ready low until the apply, then high.
- Fractional mode, ACC_WIDTH = 32, INC = 0x6666_6666 (0.4·2^32) → 20 MHz average: exactly 2 ticks per 5 clk cycles over 1000 cycles.
- Enable gating: en = 0 for 17 cycles mid-count → clk_div and count frozen, no ticks; after en = 1 the remaining count completes unchanged. A config written while en = 0 is applied on the next edge with clk_div = 0.
- Corner values: H = 0 → toggle every cycle (period 2); INC = 0 → clk_div stays 0, no tick; INC = 2^31 → clk_div alternates each cycle.
- Asynchronous reset asserted between clk edges with an update pending → outputs zero immediately, default H restored, cfg_ready = 1, pending value never applied.
